// File: rtl/gate4_exhaustive_tester_pkg.sv
// Shared types and sizes for the 4-input gate exhaustive tester.
package gate_test_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} gt_state_t;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;

endpackage

// File: rtl/gate4_exhaustive_tester_if.sv
// Control/status and gate-side signals of the exhaustive tester.
// The slave modport is the tester itself; the master modport is the host/environment.
interface gate_test_if #(
  parameter int ERR_W = 5
) ();
  import gate_test_pkg::*;

  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             first_fail_valid;
  logic [VEC_W-1:0] first_fail_vec;
  logic [VEC_W-1:0] dut_in;
  logic             dut_out;

  modport master (
    output start,
    input  busy, done, pass, err_count, first_fail_valid, first_fail_vec,
    input  dut_in,
    output dut_out
  );

  modport slave (
    input  start,
    output busy, done, pass, err_count, first_fail_valid, first_fail_vec,
    output dut_in,
    input  dut_out
  );

endinterface

// File: rtl/gate4_exhaustive_tester_settle_timer.sv
// Loadable down-counter: after a load, expired is high in the SETTLE_CYCLES-th cycle.
module gate_settle_timer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  // Parks at zero once run out, so expired is a single-cycle pulse per load.
  assign expired = (cnt == ONE);

endmodule

// File: rtl/gate4_exhaustive_tester.sv
// Exhaustive tester for a 4-input combinational gate: applies 4'h0..4'hF, checks against TRUTH_TABLE.
// Optional build macro STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module gate4_exhaustive_tester
  import gate_test_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] TRUTH_TABLE   = 16'h8000,
  parameter int                 SETTLE_CYCLES = 2,
  parameter int                 ERR_W         = 5
) (
  input logic        clk,
  input logic        rst_n,
  gate_test_if.slave bus
);

  localparam logic [VEC_W-1:0] VEC_LAST = 4'hF;
  localparam logic [VEC_W-1:0] VEC_ONE  = 4'd1;

  gt_state_t        state;
  logic [VEC_W-1:0] vec;
  logic [VEC_W-1:0] dut_in_r;
  logic [ERR_W-1:0] err_count_r;
  logic             first_fail_valid_r;
  logic [VEC_W-1:0] first_fail_vec_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;

  logic start_accept;
  logic mismatch;
  logic stop_now;
  logic finish;
  logic timer_load;
  logic timer_expired;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign start_accept = ((state == IDLE) || (state == DONE)) && bus.start;
  // Identity compare so an unknown gate response is scored as a failure.
  assign mismatch     = (bus.dut_out !== TRUTH_TABLE[vec]);

`ifdef STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  assign finish     = (state == SAMPLE) && ((vec == VEC_LAST) || stop_now);
  assign timer_load = start_accept || ((state == SAMPLE) && !finish);

  gate_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (VEC_W)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      vec                <= '0;
      dut_in_r           <= '0;
      err_count_r        <= '0;
      first_fail_valid_r <= 1'b0;
      first_fail_vec_r   <= '0;
      busy_r             <= 1'b0;
      done_r             <= 1'b0;
      pass_r             <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state              <= DRIVE;
            vec                <= '0;
            dut_in_r           <= '0;
            err_count_r        <= '0;
            first_fail_valid_r <= 1'b0;
            first_fail_vec_r   <= '0;
            busy_r             <= 1'b1;
            done_r             <= 1'b0;
            pass_r             <= 1'b0;
          end
        end
        DRIVE: begin
          if (timer_expired) state <= SAMPLE;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count_r <= sat_inc(err_count_r);
            if (!first_fail_valid_r) begin
              first_fail_valid_r <= 1'b1;
              first_fail_vec_r   <= vec;
            end
          end
          if (finish) begin
            state    <= DONE;
            dut_in_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            // Saturation never wraps to zero, so this equals err_count==0 after update.
            pass_r   <= !mismatch && (err_count_r == '0);
          end else begin
            state    <= DRIVE;
            vec      <= vec + VEC_ONE;
            dut_in_r <= vec + VEC_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dut_in           = dut_in_r;
  assign bus.err_count        = err_count_r;
  assign bus.first_fail_valid = first_fail_valid_r;
  assign bus.first_fail_vec   = first_fail_vec_r;
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.pass             = pass_r;

endmodule

// File: tb/tb_gate4_exhaustive_tester.sv
// Self-checking bench: table of gate behaviours, random faulty gates vs a truth-table model, corner sequences.
module tb_gate4_exhaustive_tester;

  logic clk;
  logic rst_n;
  logic [15:0] gate_a;
  logic [15:0] gate_b;
  int total;
  int bad;

  localparam logic [15:0] TT_A = 16'h8000;
  localparam logic [15:0] TT_B = 16'hFFFE;

  gate_test_if #(.ERR_W(5)) bus_a ();
  gate_test_if #(.ERR_W(3)) bus_b ();

  gate4_exhaustive_tester #(.TRUTH_TABLE(TT_A), .SETTLE_CYCLES(2), .ERR_W(5)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  gate4_exhaustive_tester #(.TRUTH_TABLE(TT_B), .SETTLE_CYCLES(1), .ERR_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  assign bus_a.dut_out = gate_a[bus_a.dut_in];
  assign bus_b.dut_out = gate_b[bus_b.dut_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int busy; int done; int pass; int err; int ffv; int ffvec; int dut_in;
  } obs_t;

  typedef struct {
    string       nm;
    logic [15:0] gate;
    int          err;
    int          ffv;
    int          ffvec;
  } row_t;

  function automatic obs_t obs(input int w);
    obs_t o;
    if (w == 0) begin
      o.busy = int'(bus_a.busy); o.done = int'(bus_a.done); o.pass = int'(bus_a.pass);
      o.err = int'(bus_a.err_count); o.ffv = int'(bus_a.first_fail_valid);
      o.ffvec = int'(bus_a.first_fail_vec); o.dut_in = int'(bus_a.dut_in);
    end else begin
      o.busy = int'(bus_b.busy); o.done = int'(bus_b.done); o.pass = int'(bus_b.pass);
      o.err = int'(bus_b.err_count); o.ffv = int'(bus_b.first_fail_valid);
      o.ffvec = int'(bus_b.first_fail_vec); o.dut_in = int'(bus_b.dut_in);
    end
    return o;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 0) bus_a.start = v; else bus_b.start = v;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: score each vector against the golden table, stopping early in stop-on-fail builds.
  task automatic model(input logic [15:0] g, input logic [15:0] tt, input int settle,
                       input int errmax, output int err, output int ffv, output int ffvec,
                       output int lat);
    err = 0; ffv = 0; ffvec = 0; lat = 0;
    for (int v = 0; v < 16; v++) begin
      lat += settle + 1;
      if (g[v] !== tt[v]) begin
        if (err < errmax) err++;
        if (ffv == 0) begin ffv = 1; ffvec = v; end
`ifdef STOP_ON_FAIL_EN
        break;
`endif
      end
    end
  endtask

  // Pulse start, then count cycles after the accepting edge until done (bounded).
  task automatic run(input int w, input int poke, output int lat, output int busy_cyc,
                     output obs_t first);
    @(negedge clk);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    first = obs(w);
    lat = 0; busy_cyc = 0;
    while (obs(w).done == 0 && lat < 300) begin
      if (obs(w).busy != 0) busy_cyc++;
      set_start(w, (lat == poke) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    set_start(w, 1'b0);
  endtask

  task automatic check_result(input string nm, input int w, input int e_err, input int e_ffv,
                              input int e_ffvec, input int e_lat, input int lat, input int bcyc);
    obs_t o;
    o = obs(w);
    check({nm, " latency"}, lat, e_lat);
    check({nm, " busy_cycles"}, bcyc, e_lat);
    check({nm, " done"}, o.done, 1);
    check({nm, " busy_after"}, o.busy, 0);
    check({nm, " err_count"}, o.err, e_err);
    check({nm, " pass"}, o.pass, (e_err == 0) ? 1 : 0);
    check({nm, " ff_valid"}, o.ffv, e_ffv);
    if (e_ffv != 0) check({nm, " ff_vec"}, o.ffvec, e_ffvec);
    check({nm, " dut_in_idle"}, o.dut_in, 0);
  endtask

  row_t rows[5];

  initial begin
    int lat, bcyc, e_err, e_ffv, e_ffvec, e_lat, bad_steps, waited;
    obs_t o, first;
    total = 0; bad = 0;
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    gate_a = TT_A; gate_b = TT_B;
    rst_n = 1'b0;

    rows[0] = '{"and_ok",   16'h8000, 0,  0, 0};
    rows[1] = '{"stuck0",   16'h0000, 1,  1, 15};
    rows[2] = '{"stuck1",   16'hFFFF, 15, 1, 0};
    rows[3] = '{"fault7",   16'h8080, 1,  1, 7};
    rows[4] = '{"inverted", 16'h7FFF, 16, 1, 0};

    repeat (2) @(negedge clk);
    o = obs(0);
    check("reset busy", o.busy, 0);
    check("reset done", o.done, 0);
    check("reset pass", o.pass, 0);
    check("reset err", o.err, 0);
    check("reset ffv", o.ffv, 0);
    check("reset ffvec", o.ffvec, 0);
    check("reset dut_in", o.dut_in, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of gate behaviours on the AND4 instance.
    foreach (rows[i]) begin
      gate_a = rows[i].gate;
      e_err = rows[i].err; e_ffv = rows[i].ffv; e_ffvec = rows[i].ffvec; e_lat = 48;
`ifdef STOP_ON_FAIL_EN
      if (e_err > 0) begin e_err = 1; e_lat = (e_ffvec + 1) * 3; end
`endif
      run(0, -1, lat, bcyc, first);
      check({rows[i].nm, " start_busy"}, first.busy, 1);
      check_result(rows[i].nm, 0, e_err, e_ffv, e_ffvec, e_lat, lat, bcyc);
    end

    // Random faulty gates against the model.
    for (int i = 0; i < 16; i++) begin
      gate_a = (i % 4 == 0) ? TT_A : 16'($urandom);
      model(gate_a, TT_A, 2, 31, e_err, e_ffv, e_ffvec, e_lat);
      run(0, -1, lat, bcyc, first);
      check_result($sformatf("rand%0d", i), 0, e_err, e_ffv, e_ffvec, e_lat, lat, bcyc);
    end

    // OR4 instance, one settle cycle: dut_in must step 0..F, each value held two cycles.
    gate_b = TT_B;
    @(negedge clk);
    set_start(1, 1'b1);
    @(posedge clk); #1;
    set_start(1, 1'b0);
    bad_steps = 0;
    for (int k = 0; k < 32; k++) begin
      if (obs(1).dut_in != k / 2) bad_steps++;
      if (k < 31) begin @(posedge clk); #1; end
    end
    check("or4 dut_in_steps_bad", bad_steps, 0);
    check("or4 done_before_32", obs(1).done, 0);
    @(posedge clk); #1;
    check("or4 done_at_32", obs(1).done, 1);
    check("or4 pass", obs(1).pass, 1);

    // OR4 instance with a dead gate: the 3-bit error counter saturates.
    gate_b = 16'h0000;
    model(gate_b, TT_B, 1, 7, e_err, e_ffv, e_ffvec, e_lat);
    run(1, -1, lat, bcyc, first);
    check_result("or4_sat", 1, e_err, e_ffv, e_ffvec, e_lat, lat, bcyc);

    // Asynchronous reset while vector 7 is on the bus.
    gate_a = TT_A;
    @(negedge clk);
    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    waited = 0;
    while (obs(0).dut_in != 7 && waited < 100) begin @(posedge clk); #1; waited++; end
    check("rst wait_vec7_timeout", (waited < 100) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    o = obs(0);
    check("midrst busy", o.busy, 0);
    check("midrst dut_in", o.dut_in, 0);
    check("midrst err", o.err + o.ffv + o.ffvec + o.done + o.pass, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst idle dut_in", obs(0).dut_in, 0);
    check("postrst idle busy", obs(0).busy, 0);
    run(0, -1, lat, bcyc, first);
    check_result("after_rst", 0, 0, 0, 0, 48, lat, bcyc);

    // start while busy is ignored; start in DONE clears results and restarts.
    gate_a = 16'h0000;
    e_lat = 48;
`ifdef STOP_ON_FAIL_EN
    e_lat = 48;
`endif
    run(0, 10, lat, bcyc, first);
    check_result("start_busy_ignored", 0, 1, 1, 15, e_lat, lat, bcyc);
    gate_a = TT_A;
    run(0, -1, lat, bcyc, first);
    check("restart done_cleared", first.done, 0);
    check("restart err_cleared", first.err, 0);
    check("restart ffv_cleared", first.ffv, 0);
    check("restart busy", first.busy, 1);
    check_result("restart", 0, 0, 0, 0, 48, lat, bcyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
